// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the score seven-segment display path.
package sevenseg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    // Segment patterns are {g,f,e,d,c,b,a}, active low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_H     = 7'b0001001;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Decimal digit to segment pattern; anything above 9 shows as blank.
    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[d];
    endfunction

endpackage

// File: rtl/score_bcd_conv.sv
// Sequential shift-add-3 binary to BCD converter. The display registers only
// change in DONE, so a half-converted value is never visible downstream.
module score_bcd_conv
    import sevenseg_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] bin,
    output logic [3:0] bcd_h,
    output logic [3:0] bcd_t,
    output logic [3:0] bcd_o
);

    conv_state_t state;
    conv_state_t state_next;

    logic [7:0]  last_score;
    logic [7:0]  sh;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [19:0] shifted;
    logic [2:0]  cnt;

    // Converter state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start on a new score, leave SHIFT after the eighth shift.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bin != last_score) state_next = SHIFT;
            SHIFT:   if (cnt == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add 3 to every BCD nibble of 5 or more so the following shift carries correctly.
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
        if (bcd[11:8] >= 4'd5) bcd_adj[11:8] = bcd[11:8] + 4'd3;
    end

    assign shifted = {bcd_adj, sh} << 1;

    // Datapath: latch the new score, shift it through the BCD register, publish in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_score <= '0;
            sh         <= '0;
            bcd        <= '0;
            cnt        <= '0;
            bcd_h      <= '0;
            bcd_t      <= '0;
            bcd_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bin != last_score) begin
                        last_score <= bin;
                        sh         <= bin;
                        bcd        <= '0;
                        cnt        <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, sh} <= shifted;
                    cnt       <= cnt + 3'd1;
                end
                DONE: begin
                    bcd_h <= bcd[11:8];
                    bcd_t <= bcd[7:4];
                    bcd_o <= bcd[3:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/score_sevenseg.sv
// Four-digit multiplexed seven-segment driver for the game score, with
// leading-zero blanking and an 'H' on the leftmost digit while hit is high.
module score_sevenseg
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] score,
    input  logic       hit,
    output logic [3:0] an,
    output logic [6:0] seg
);

    logic [REFRESH_BITS-1:0] scan_cnt;
    logic [1:0]              sel;
    logic [3:0]              disp_h;
    logic [3:0]              disp_t;
    logic [3:0]              disp_o;
    logic [3:0]              an_next;
    logic [6:0]              seg_next;

    score_bcd_conv u_conv (
        .clk     (clk),
        .reset_n (reset_n),
        .bin     (score),
        .bcd_h   (disp_h),
        .bcd_t   (disp_t),
        .bcd_o   (disp_o)
    );

    assign sel     = scan_cnt[REFRESH_BITS-1 -: 2];
    assign an_next = ~(4'b0001 << sel);

    // Pick the pattern for the selected digit, blanking leading zeros.
    always_comb begin
        seg_next = SEG_BLANK;
        case (sel)
            2'd0: seg_next = digit_seg(disp_o);
            2'd1: seg_next = (disp_h == 4'd0 && disp_t == 4'd0) ? SEG_BLANK : digit_seg(disp_t);
            2'd2: seg_next = (disp_h == 4'd0) ? SEG_BLANK : digit_seg(disp_h);
            2'd3: seg_next = hit ? SEG_H : SEG_BLANK;
            default: seg_next = SEG_BLANK;
        endcase
    end

    // Free-running scan counter plus anode and segment registers loaded from the same sel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt <= '0;
            an       <= 4'b1111;
            seg      <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_cnt + REFRESH_BITS'(1);
            an       <= an_next;
            seg      <= seg_next;
        end
    end

endmodule
